// File: rtl/fcvt_result_stage.sv
// Float-to-int result stage: NaN/range fix-up of the converter's integer and
// {NV,DZ,OF,UF,NX} generation, behind a 2-entry skid buffer with sticky flags.
module fcvt_result_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_f,
  input  logic        in_is_unsigned,
  input  logic [31:0] in_int,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic [4:0]  out_flags,
  output logic [4:0]  fflags_acc,
  input  logic        fflags_clr
);

  logic              sign;
  logic [7:0]        exp_f;
  logic [22:0]       mant;
  logic signed [8:0] e;
  logic              is_nan;
  logic              is_inf;
  logic              nv;
  logic              nx;
  logic [22:0]       frac_mask;
  logic [31:0]       fix_int;
  logic [4:0]        fix_flags;

  assign sign   = in_f[31];
  assign exp_f  = in_f[30:23];
  assign mant   = in_f[22:0];
  assign e      = $signed({1'b0, exp_f}) - 9'sd127;
  assign is_nan = (exp_f == 8'hFF) && (mant != 23'd0);
  assign is_inf = (exp_f == 8'hFF) && (mant == 23'd0);

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    fix_int   = in_int;
    frac_mask = '0;
    nx        = 1'b0;

    if (is_nan)
      fix_int = in_is_unsigned ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    else if (e < 9'sd0)
      fix_int = '0;
    else if (in_is_unsigned && sign)
      fix_int = '0;

    // -2^31 is the one signed e==31 value that is exactly representable.
    nv = is_nan || is_inf
       || (!in_is_unsigned && (e >= 9'sd31) && (in_f != 32'hCF00_0000))
       || (in_is_unsigned && (e >= 9'sd32))
       || (in_is_unsigned && sign && (e >= 9'sd0));

    if (e < 9'sd0) begin
      nx = |in_f[30:0];
    end else if (e <= 9'sd22) begin
      frac_mask = 23'h7F_FFFF >> e[4:0];
      nx        = |(mant & frac_mask);
    end
    if (nv)
      nx = 1'b0;

    fix_flags = {nv, 3'b000, nx};
  end

  logic        accept;
  logic        drain;
  logic        skid_valid;
  logic [31:0] skid_int;
  logic [4:0]  skid_flags;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: data registers are reset too, so out_int/out_flags read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_int    <= '0;
      out_flags  <= '0;
      skid_valid <= 1'b0;
      skid_int   <= '0;
      skid_flags <= '0;
    end else if (drain) begin
      if (skid_valid) begin
        out_int    <= skid_int;
        out_flags  <= skid_flags;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_int   <= fix_int;
        out_flags <= fix_flags;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_int   <= fix_int;
        out_flags <= fix_flags;
      end else begin
        skid_valid <= 1'b1;
        skid_int   <= fix_int;
        skid_flags <= fix_flags;
      end
    end
  end

  // A clear coinciding with a delivery keeps only the delivered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fflags_acc <= '0;
    else if (fflags_clr)
      fflags_acc <= drain ? out_flags : 5'd0;
    else if (drain)
      fflags_acc <= fflags_acc | out_flags;
  end

endmodule

// File: tb/tb_fcvt_result_stage.sv
// Bench for fcvt_result_stage: directed test-plan vectors then randomized traffic,
// scored against an arithmetic model of the conversion and a FIFO occupancy model.
module tb_fcvt_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_f;
  logic        in_is_unsigned;
  logic [31:0] in_int;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_int;
  logic [4:0]  out_flags;
  logic [4:0]  fflags_acc;
  logic        fflags_clr;

  fcvt_result_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_f           (in_f),
    .in_is_unsigned (in_is_unsigned),
    .in_int         (in_int),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_int        (out_int),
    .out_flags      (out_flags),
    .fflags_acc     (fflags_acc),
    .fflags_clr     (fflags_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] v;
    logic [4:0]  f;
  } beat_t;

  int          checks   = 0;
  int          failures = 0;
  beat_t       q[$];
  logic [4:0]  acc_model = '0;
  logic [31:0] specials [8] = '{32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000, 32'hCF00_0000,
                                32'h4F00_0000, 32'h4F80_0000, 32'h8000_0000, 32'h0000_0001};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value-level model: truncate |x| exactly, then decide range and inexactness.
  function automatic beat_t ref_model(input logic [31:0] f, input logic uns, input logic [31:0] raw);
    beat_t            r;
    logic             s;
    int               ex;
    int               e;
    longint unsigned  m;
    longint unsigned  mag;
    logic             inexact;
    logic             nan;
    logic             inf;
    logic             nv;
    s   = f[31];
    ex  = int'(f[30:23]);
    nan = (ex == 255) && (f[22:0] != 0);
    inf = (ex == 255) && (f[22:0] == 0);
    m   = {40'd0, 1'b1, f[22:0]};
    e   = ex - 127;
    if (ex == 0) begin
      mag = 0; inexact = (f[22:0] != 0);
    end else if (e < 0) begin
      mag = 0; inexact = 1'b1;
    end else if (e >= 40) begin
      mag = 64'h0000_0100_0000_0000; inexact = 1'b0;
    end else if (e >= 23) begin
      mag = m << (e - 23); inexact = 1'b0;
    end else begin
      mag = m >> (23 - e); inexact = ((mag << (23 - e)) != m);
    end
    if (uns)
      nv = nan || inf || (mag > 64'hFFFF_FFFF) || (s && mag != 0);
    else
      nv = nan || inf || (s ? (mag > 64'h8000_0000) : (mag > 64'h7FFF_FFFF));
    if (nan)
      r.v = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    else if (mag == 0 || (uns && s))
      r.v = 32'd0;
    else
      r.v = raw;
    r.f = {nv, 3'b000, (!nv && inexact)};
    return r;
  endfunction

  // One clock: drive at posedge+1, predict transfers, then check state after the edge.
  task automatic step(input logic iv, input logic [31:0] f, input logic uns,
                      input logic [31:0] raw, input logic ordy, input logic clr);
    logic take;
    logic give;
    in_valid       = iv;
    in_f           = f;
    in_is_unsigned = uns;
    in_int         = raw;
    out_ready      = ordy;
    fflags_clr     = clr;
    take = iv && (q.size() < 2);
    give = ordy && (q.size() != 0);
    @(posedge clk);
    if (give) begin
      acc_model = clr ? q[0].f : (acc_model | q[0].f);
      void'(q.pop_front());
    end else if (clr) begin
      acc_model = '0;
    end
    if (take)
      q.push_back(ref_model(f, uns, raw));
    #1;
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, q.size() < 2);
    check("fflags_acc", fflags_acc, acc_model);
    if (q.size() != 0) begin
      check("out_int", out_int, q[0].v);
      check("out_flags", out_flags, q[0].f);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_f = 0; in_is_unsigned = 0; in_int = 0;
    out_ready = 0; fflags_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_int", out_int, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_acc", fflags_acc, 0);
    rst = 1'b0;

    // Test-plan vectors, each drained the following cycle.
    step(1, 32'h4020_0000, 0, 32'd2, 1, 0);
    check("plan_2p5_int", out_int, 32'h2);
    check("plan_2p5_flags", out_flags, 5'h01);
    step(1, 32'h4F00_0000, 0, 32'h7FFF_FFFF, 1, 0);
    check("plan_p2_31_int", out_int, 32'h7FFF_FFFF);
    check("plan_p2_31_flags", out_flags, 5'h10);
    step(1, 32'hCF00_0000, 0, 32'h8000_0000, 1, 0);
    check("plan_m2_31_int", out_int, 32'h8000_0000);
    check("plan_m2_31_flags", out_flags, 5'h00);
    step(1, 32'h3F00_0000, 1, 32'hFFFF_FFFF, 1, 0);
    check("plan_u_half_int", out_int, 32'h0);
    check("plan_u_half_flags", out_flags, 5'h01);
    step(1, 32'hBF80_0000, 1, 32'h1234_5678, 1, 0);
    check("plan_u_m1_int", out_int, 32'h0);
    check("plan_u_m1_flags", out_flags, 5'h10);
    step(1, 32'h8000_0000, 1, 32'h0, 1, 0);
    check("plan_u_m0_int", out_int, 32'h0);
    check("plan_u_m0_flags", out_flags, 5'h00);
    step(1, 32'h7FC0_0000, 1, 32'h0, 1, 0);
    check("plan_nan_u_int", out_int, 32'hFFFF_FFFF);
    check("plan_nan_u_flags", out_flags, 5'h10);
    step(1, 32'h7FC0_0000, 0, 32'h0, 1, 0);
    check("plan_nan_s_int", out_int, 32'h7FFF_FFFF);
    check("plan_nan_s_flags", out_flags, 5'h10);

    // Backpressure: two beats fill main and skid, the third waits, then all drain in order.
    step(0, 32'h0, 0, 32'h0, 1, 1);
    step(1, 32'h3F80_0000, 0, 32'd1, 0, 0);
    step(1, 32'h4020_0000, 0, 32'd2, 0, 0);
    check("bp_full_ready", in_ready, 0);
    step(1, 32'h4F80_0000, 1, 32'd3, 0, 0);
    check("bp_hold_int", out_int, 32'd1);
    step(1, 32'h4F80_0000, 1, 32'd3, 1, 0);
    check("bp_second_int", out_int, 32'd2);
    step(1, 32'h4F80_0000, 1, 32'd3, 1, 0);
    check("bp_third_int", out_int, 32'd3);
    step(0, 32'h0, 0, 32'h0, 1, 0);
    check("bp_acc_or", fflags_acc, 5'h11);

    // Clear coinciding with a delivery of flags 0x01 over an accumulator of 0x10.
    step(1, 32'h7FC0_0000, 0, 32'h0, 1, 1);
    step(1, 32'h4020_0000, 0, 32'd2, 1, 0);
    check("clr_pre_acc", fflags_acc, 5'h10);
    step(0, 32'h0, 0, 32'h0, 1, 1);
    check("clr_xfer_acc", fflags_acc, 5'h01);

    // Reset while the skid register holds a beat.
    step(1, 32'h4040_0000, 0, 32'd3, 0, 0);
    step(1, 32'h4080_0000, 0, 32'd4, 0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_acc", fflags_acc, 0);
    q.delete();
    acc_model = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic with random backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] f;
      int          kind;
      kind = int'($urandom_range(0, 5));
      if (kind == 0)
        f = $urandom;
      else if (kind == 1)
        f = specials[$urandom_range(0, 7)];
      else
        f = {1'($urandom), 8'($urandom_range(110, 162)), 23'($urandom)};
      step(($urandom_range(0, 3) != 0), f, 1'($urandom), $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++)
      step(0, 32'h0, 0, 32'h0, 1, 0);
    check("final_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcvt_result_stage.md
Name: fcvt_result_stage

Overview:
- Registered output stage directly downstream of the combinational float-to-int converter in the FPU convert path.
- Takes the converter's 32-bit integer, plus the original float operand and signedness, and applies range and NaN fix-ups to produce the final integer.
- Computes RISC-V style exception flags and presents result plus flags on a valid/ready interface.
- Contains a 2-entry skid buffer and a sticky flag accumulator.

Parameters:
- None. Widths are fixed: 32-bit float, 32-bit integer, 5-bit flags.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_f  in  32  original IEEE-754 single operand
- in_is_unsigned  in  1  1 = unsigned conversion, 0 = signed
- in_int  in  32  raw integer from the converter for in_f
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_int  out  32  final integer
- out_flags  out  5  {NV,DZ,OF,UF,NX} for this result
- fflags_acc  out  5  sticky OR of all delivered out_flags
- fflags_clr  in  1  clear the accumulator

Behaviour:
- Reset: async on rst high. out_valid=0, in_ready=1, skid empty, out_int=0, out_flags=0, fflags_acc=0.
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Definitions: e = in_f[30:23] - 127, signed 9-bit. nan = exp==255 && mant!=0. inf = exp==255 && mant==0.
- Final integer, first match wins:
  - nan: signed 0x7FFFFFFF, unsigned 0xFFFFFFFF.
  - e<0 (|f|<1, including zero and denormals): 0.
  - unsigned and sign=1: 0.
  - otherwise: in_int, passed unmodified.
- NV is set when any of:
  - nan or inf;
  - signed and e>=31, except in_f==0xCF000000 exactly (-2^31, no flag);
  - unsigned and e>=32;
  - unsigned and sign=1 and e>=0.
- NX:
  - Only when NV=0.
  - e<0: NX = (in_f[30:0]!=0).
  - 0<=e<=22: NX = OR of mantissa bits [22-e:0].
  - e>=23: NX = 0.
- DZ, OF, UF: always 0.
- Latency and throughput:
  - Flags and final integer are computed combinationally at the input and registered on the input transfer.
  - Beat accepted at cycle N appears with out_valid=1 at N+1.
  - Full throughput of 1 beat/cycle while out_ready=1.
- Skid buffer:
  - Two registers: main drives the outputs; skid holds overflow.
  - in_ready is registered and equals !skid_valid.
  - Accept with main empty, or main draining this cycle with skid empty: write main.
  - Accept with main full and not draining: write skid, in_ready goes 0 next cycle.
  - Drain with skid full: main<=skid, skid empties, in_ready goes 1 next cycle.
  - Drain and accept in the same cycle with skid full cannot occur because in_ready=0.
  - Strict FIFO order.
  - out_int and out_flags hold stable while out_valid && !out_ready.
- Accumulator:
  - On output transfer: fflags_acc |= out_flags.
  - fflags_clr alone: fflags_acc = 0 next cycle.
  - fflags_clr together with an output transfer: fflags_acc = out_flags of that transfer. The clear applies first; the delivered flags survive.
- Reset mid-operation: all buffered beats are discarded and the accumulator is cleared. No output transfer occurs in the reset cycle.

Test Plan:
- Signed 2.5: in_f=0x40200000, in_int=2 -> next cycle out_int=0x00000002, out_flags=0x01.
- Signed 2^31 and -2^31:
  - in_f=0x4F000000, in_int=0x7FFFFFFF -> out_int=0x7FFFFFFF, out_flags=0x10.
  - in_f=0xCF000000, in_int=0x80000000 -> out_int=0x80000000, out_flags=0x00.
- Unsigned small and negative:
  - in_f=0x3F000000 (0.5), in_int=0xFFFFFFFF -> out_int=0, flags=0x01.
  - in_f=0xBF800000 (-1.0) -> out_int=0, flags=0x10.
  - in_f=0x80000000 -> out_int=0, flags=0x00.
- NaN: in_f=0x7FC00000 unsigned -> out_int=0xFFFFFFFF, flags=0x10. Same input signed -> out_int=0x7FFFFFFF, flags=0x10.
- Backpressure:
  - Hold out_ready=0, offer 3 beats (ints 1,2,3) -> beats 1,2 accepted, in_ready=0 from the cycle after beat 2.
  - Raise out_ready -> outputs appear in order 1,2,3 on consecutive cycles.
  - fflags_acc equals the OR of all three beats' flags.
- Clear and reset:
  - fflags_clr with a simultaneous transfer of flags 0x01 over acc=0x10 -> acc=0x01.
  - Assert rst while skid is full -> out_valid=0 and in_ready=1 immediately, fflags_acc=0.
